secuenciador_inicializacion: RTL and testbench

//  Power-up initialisation sequencer for the RTC interface: on start, issues a fixed

---
 rtl/secuenciador_inicializacion.sv | 162 ++++++++++++++++
 tb/tb_secuenciador_inicializacion.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_inicializacion.sv
// Power-up initialisation sequencer: walks a fixed address/data table, issuing one
// req/ack write per step to the bus write engine with a fixed idle gap between writes.
module secuenciador_inicializacion #(
    parameter int N_PASOS = 6,
    parameter int ESPERA  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       wr_ack,
    output logic       wr_req,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [2:0] paso,
    output logic       ocupado,
    output logic       listo,
    output logic       error
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int EW = (ESPERA > 1) ? $clog2(ESPERA) : 1;

    localparam logic [TW-1:0] T_ZERO = '0;
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [EW-1:0] G_ZERO = '0;
    localparam logic [EW-1:0] G_ONE  = EW'(1);
    localparam logic [EW-1:0] G_LAST = EW'(ESPERA - 1);
    localparam logic [2:0]    P_LAST = 3'(N_PASOS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ESCRIBE = 3'd1,
        ST_ESPERA  = 3'd2,
        ST_FIN     = 3'd3,
        ST_ERROR   = 3'd4
    } estado_t;

    // Fixed RTC init table; returns {addr, data} for a step index.
    function automatic logic [15:0] tabla(input logic [2:0] idx);
        logic [15:0] val;
        case (idx)
            3'd0:    val = {8'h02, 8'h10};
            3'd1:    val = {8'h02, 8'h00};
            3'd2:    val = {8'h10, 8'hD2};
            3'd3:    val = {8'h00, 8'h00};
            3'd4:    val = {8'h01, 8'h00};
            3'd5:    val = {8'hF1, 8'h00};
            3'd6:    val = {8'h00, 8'h00};
            3'd7:    val = {8'h00, 8'h00};
            default: val = {8'h00, 8'h00};
        endcase
        return val;
    endfunction

    estado_t       estado_r, estado_s;
    logic [2:0]    paso_r, paso_s;
    logic [TW-1:0] tcnt_r, tcnt_s;
    logic [EW-1:0] gcnt_r, gcnt_s;
    logic          listo_r, listo_s;
    logic          error_r, error_s;
    logic          wr_req_r, wr_req_s;
    logic          ocupado_r, ocupado_s;
    logic [7:0]    addr_r, addr_s;
    logic [7:0]    data_r, data_s;

    // Next-state, step index, counters and next registered outputs.
    always_comb begin
        estado_s = estado_r;
        paso_s   = paso_r;
        tcnt_s   = tcnt_r;
        gcnt_s   = gcnt_r;
        listo_s  = listo_r;
        error_s  = error_r;
        case (estado_r)
            ST_IDLE, ST_FIN, ST_ERROR: begin
                if (start) begin
                    estado_s = ST_ESCRIBE;
                    paso_s   = 3'd0;
                    listo_s  = 1'b0;
                    error_s  = 1'b0;
                    tcnt_s   = T_ZERO;
                    gcnt_s   = G_ZERO;
                end else begin
                    estado_s = estado_r;
                end
            end
            ST_ESCRIBE: begin
                // An ack on the expiry edge still counts as a successful write.
                if (wr_ack) begin
                    estado_s = ST_ESPERA;
                    tcnt_s   = T_ZERO;
                    gcnt_s   = G_ZERO;
                end else if (tcnt_r == T_LAST) begin
                    estado_s = ST_ERROR;
                    error_s  = 1'b1;
                    tcnt_s   = T_ZERO;
                end else begin
                    tcnt_s = tcnt_r + T_ONE;
                end
            end
            ST_ESPERA: begin
                if (gcnt_r == G_LAST) begin
                    gcnt_s = G_ZERO;
                    if (paso_r == P_LAST) begin
                        estado_s = ST_FIN;
                        listo_s  = 1'b1;
                    end else begin
                        estado_s = ST_ESCRIBE;
                        paso_s   = paso_r + 3'd1;
                    end
                end else begin
                    gcnt_s = gcnt_r + G_ONE;
                end
            end
            default: begin
                estado_s = ST_IDLE;
                paso_s   = 3'd0;
            end
        endcase
        wr_req_s          = (estado_s == ST_ESCRIBE);
        ocupado_s         = (estado_s == ST_ESCRIBE) || (estado_s == ST_ESPERA);
        {addr_s, data_s}  = tabla(paso_s);
    end

    // State and output registers; outputs come straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_r  <= ST_IDLE;
            paso_r    <= 3'd0;
            tcnt_r    <= T_ZERO;
            gcnt_r    <= G_ZERO;
            listo_r   <= 1'b0;
            error_r   <= 1'b0;
            wr_req_r  <= 1'b0;
            ocupado_r <= 1'b0;
            addr_r    <= 8'h00;
            data_r    <= 8'h00;
        end else begin
            estado_r  <= estado_s;
            paso_r    <= paso_s;
            tcnt_r    <= tcnt_s;
            gcnt_r    <= gcnt_s;
            listo_r   <= listo_s;
            error_r   <= error_s;
            wr_req_r  <= wr_req_s;
            ocupado_r <= ocupado_s;
            addr_r    <= addr_s;
            data_r    <= data_s;
        end
    end

    assign wr_req  = wr_req_r;
    assign wr_addr = addr_r;
    assign wr_data = data_r;
    assign paso    = paso_r;
    assign ocupado = ocupado_r;
    assign listo   = listo_r;
    assign error   = error_r;

endmodule

// File: tb/tb_secuenciador_inicializacion.sv
// Scoreboard bench for secuenciador_inicializacion: expected writes are queued at
// start and checked as the bench-side write engine acks each request.
module tb_secuenciador_inicializacion;

    localparam int N_PASOS = 6;
    localparam int ESPERA  = 4;
    localparam int TIMEOUT = 255;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [2:0] p;
    } exp_t;

    logic       clk, reset, start, wr_ack;
    logic       wr_req, ocupado, listo, error;
    logic [7:0] wr_addr, wr_data;
    logic [2:0] paso;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   t0;

    logic [7:0] ref_addr [8] = '{8'h02, 8'h02, 8'h10, 8'h00, 8'h01, 8'hF1, 8'h00, 8'h00};
    logic [7:0] ref_data [8] = '{8'h10, 8'h00, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    secuenciador_inicializacion #(
        .N_PASOS(N_PASOS), .ESPERA(ESPERA), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .wr_ack(wr_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .paso(paso),
        .ocupado(ocupado), .listo(listo), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_seq();
        exp_t e;
        for (int i = 0; i < N_PASOS; i++) begin
            e.a = ref_addr[i];
            e.d = ref_data[i];
            e.p = 3'(i);
            sb.push_back(e);
        end
    endtask

    // Act as the write engine for one step: wait for req, hold ack off 'delay' cycles.
    task automatic serve_step(input int delay);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wr_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_val("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check_val("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_val("addr", 32'(wr_addr), 32'(e.a));
        check_val("data", 32'(wr_data), 32'(e.d));
        check_val("paso", 32'(paso), 32'(e.p));
        check_val("busy_req", 32'(ocupado), 32'd1);
        for (int i = 0; i < delay; i++) begin
            tick();
            check_val("req_hold", 32'(wr_req), 32'd1);
            check_val("addr_hold", 32'(wr_addr), 32'(e.a));
            check_val("data_hold", 32'(wr_data), 32'(e.d));
            check_val("paso_hold", 32'(paso), 32'(e.p));
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check_val("req_drop", 32'(wr_req), 32'd0);
        check_val("busy_gap", 32'(ocupado), 32'd1);
    endtask

    task automatic wait_listo();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (listo === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_val("listo_seen", 32'(seen), 32'd1);
        check_val("fin_idle", 32'(ocupado), 32'd0);
    endtask

    task automatic do_start();
        push_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_req", 32'(wr_req), 32'd1);
        check_val("start_paso", 32'(paso), 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        wr_ack = 1'b0;
        #3;
        check_val("rst_req", 32'(wr_req), 32'd0);
        check_val("rst_listo", 32'(listo), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        #9 reset = 1'b1;

        // Idle after reset with start low
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("idle_req", 32'(wr_req), 32'd0);
            check_val("idle_busy", 32'(ocupado), 32'd0);
            check_val("idle_flags", 32'({listo, error}), 32'd0);
            check_val("idle_paso", 32'(paso), 32'd0);
        end

        // Full run, ack one cycle late, exact gap before listo
        do_start();
        for (int s = 0; s < N_PASOS; s++) serve_step(1);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < ESPERA - 1; i++) begin
            tick();
            check_val("last_gap_busy", 32'(ocupado), 32'd1);
            check_val("last_gap_listo", 32'(listo), 32'd0);
        end
        tick();
        check_val("listo_rise", 32'(listo), 32'd1);
        check_val("fin_busy", 32'(ocupado), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("listo_held", 32'(listo), 32'd1);
        end

        // Slow ack: request held stable for 10 cycles per step
        do_start();
        check_val("start_clr_listo", 32'(listo), 32'd0);
        for (int s = 0; s < N_PASOS; s++) serve_step(10);
        wait_listo();

        // Ack timeout on step 2
        do_start();
        serve_step(1);
        serve_step(1);
        for (int i = 0; i < 40 && wr_req !== 1'b1; i++) tick();
        check_val("t_paso", 32'(paso), 32'd2);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check_val("t_req_last", 32'(wr_req), 32'd1);
        check_val("t_err_early", 32'(error), 32'd0);
        tick();
        check_val("t_error", 32'(error), 32'd1);
        check_val("t_req_off", 32'(wr_req), 32'd0);
        check_val("t_paso_held", 32'(paso), 32'd2);
        check_val("t_busy_off", 32'(ocupado), 32'd0);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check_val("t_ack_ignored", 32'(error), 32'd1);
        sb.delete();

        // Restart after error, immediate ack, listo latency from first req
        do_start();
        check_val("restart_err_clr", 32'(error), 32'd0);
        t0 = cyc;
        for (int s = 0; s < N_PASOS; s++) serve_step(0);
        wait_listo();
        check_val("listo_latency", 32'(cyc - t0), 32'(N_PASOS * (1 + ESPERA)));

        // start during ESPERA of step 3 ignored; then restart from FIN
        do_start();
        for (int s = 0; s < 4; s++) serve_step(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("gap_start_req", 32'(wr_req), 32'd0);
        check_val("gap_start_busy", 32'(ocupado), 32'd1);
        check_val("gap_start_paso", 32'(paso), 32'd3);
        serve_step(1);
        serve_step(1);
        wait_listo();
        do_start();
        check_val("fin_restart_listo", 32'(listo), 32'd0);
        for (int s = 0; s < N_PASOS; s++) serve_step(2);
        wait_listo();

        // Asynchronous reset during ESCRIBE of step 4
        do_start();
        for (int s = 0; s < 4; s++) serve_step(1);
        for (int i = 0; i < 40 && wr_req !== 1'b1; i++) tick();
        check_val("ar_paso_pre", 32'(paso), 32'd4);
        #2 reset = 1'b0;
        #1;
        check_val("ar_req", 32'(wr_req), 32'd0);
        check_val("ar_busy", 32'(ocupado), 32'd0);
        check_val("ar_paso", 32'(paso), 32'd0);
        check_val("ar_addr", 32'({wr_addr, wr_data}), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("post_rst_req", 32'(wr_req), 32'd0);
            check_val("post_rst_busy", 32'(ocupado), 32'd0);
            check_val("post_rst_paso", 32'(paso), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
